// File: rtl/regfile_dump.sv
// Sequential reader that walks x0..x(NUM_REGS-1) through one regfile read port and streams
// each (index, value) beat over valid/ready while holding the core stalled.
module regfile_dump #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IDX_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             core_stall,
  output logic [IDX_W-1:0] rs_addr,
  input  logic [XLEN-1:0]  rv_in,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [IDX_W-1:0] dump_idx,
  output logic [XLEN-1:0]  dump_data
);

  typedef enum logic [2:0] {StIdle, StStall, StRead, StSend, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REGS - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      core_stall <= 1'b0;
      rs_addr    <= '0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
    end else begin
      done <= 1'b0;
      if (state_q != StIdle && abort) begin
        // Abort beats a simultaneous handshake: the in-flight beat is simply dropped.
        state_q    <= StIdle;
        idx_q      <= '0;
        rs_addr    <= '0;
        busy       <= 1'b0;
        core_stall <= 1'b0;
        dump_valid <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            idx_q   <= '0;
            rs_addr <= '0;
            if (start) begin
              state_q    <= StStall;
              busy       <= 1'b1;
              core_stall <= 1'b1;
            end
          end
          StStall: state_q <= StRead;
          StRead: begin
            dump_data  <= rv_in;
            dump_idx   <= idx_q;
            dump_valid <= 1'b1;
            state_q    <= StSend;
          end
          StSend: begin
            if (dump_ready) begin
              dump_valid <= 1'b0;
              if (idx_q == LastIdx) begin
                state_q <= StDone;
                done    <= 1'b1;
              end else begin
                idx_q   <= idx_q + 1'b1;
                rs_addr <= idx_q + 1'b1;
                state_q <= StRead;
              end
            end
          end
          StDone: begin
            state_q    <= StIdle;
            busy       <= 1'b0;
            core_stall <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural regfile and a beat collector.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst, start, abort, dump_ready;
  logic        busy, done, core_stall, dump_valid;
  logic [4:0]  rs_addr, dump_idx;
  logic [31:0] rv_in, dump_data;

  logic [31:0] rf [32];
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic [36:0] beats[$];

  regfile_dump #(.NUM_REGS(32), .XLEN(32), .IDX_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .core_stall (core_stall),
    .rs_addr    (rs_addr),
    .rv_in      (rv_in),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (we) rf[waddr] <= wdata;
  assign rv_in = rf[rs_addr];

  // Record every delivered beat; an abort in the handshake cycle voids the beat.
  always @(negedge clk) begin
    if (!rst && dump_valid && dump_ready && !abort) beats.push_back({dump_idx, dump_data});
    if (!rst && done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_val(input int i, input bit wbr);
    if (wbr && i == 5) return 32'hDEAD_BEEF;
    return (i < 31) ? 32'(i) : 32'd0;
  endfunction

  task automatic check_queue(input string tag, input int base, input int n, input bit wbr);
    logic [36:0] b;
    check({tag, "_count"}, 32'(beats.size() - base), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (base + k < beats.size()) begin
        b = beats[base + k];
        check({tag, "_idx"}, 32'(b[36:32]), 32'(k));
        check({tag, "_data"}, b[31:0], exp_val(k, wbr));
      end
    end
  endtask

  initial begin
    int base;
    int dbase;
    bit ev;
    rst = 1'b1; start = 1'b0; abort = 1'b0; dump_ready = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0;

    // Preload through the write port: r[i]=i, r[31]=0.
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = exp_val(i, 1'b0);
      step();
    end
    we = 1'b0;

    // Reset asserted mid-cycle during beat 1.
    rst = 1'b0; start = 1'b1; dump_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("pre_rst_valid", 32'(dump_valid), 32'd1);
    check("pre_rst_idx", 32'(dump_idx), 32'd1);
    #2;
    start = 1'b1; rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_stall", 32'(core_stall), 32'd0);
    check("rst_valid", 32'(dump_valid), 32'd0);
    check("rst_rs_addr", 32'(rs_addr), 32'd0);
    check("rst_idx", 32'(dump_idx), 32'd0);
    check("rst_data", dump_data, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_busy", 32'(busy), 32'd0);
      check("rst_hold_valid", 32'(dump_valid), 32'd0);
      check("rst_hold_stall", 32'(core_stall), 32'd0);
    end
    step();
    start = 1'b0; rst = 1'b0;
    step();

    // Full dump, ready tied high, cycle-exact.
    base = beats.size();
    start = 1'b1; dump_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 68; c++) begin
      @(negedge clk);
      ev = (c >= 3 && c <= 65 && (c % 2) == 1);
      check("full_valid", 32'(dump_valid), 32'(ev));
      check("full_busy", 32'(busy), 32'(c <= 66));
      check("full_stall", 32'(core_stall), 32'(c <= 66));
      check("full_done", 32'(done), 32'(c == 66));
      if (ev) begin
        check("full_idx", 32'(dump_idx), 32'((c - 3) / 2));
        check("full_data", dump_data, exp_val((c - 3) / 2, 1'b0));
      end
    end
    check_queue("full_q", base, 32, 1'b0);
    step();

    // Backpressure on beat 7 for 5 cycles.
    base = beats.size(); dbase = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 74; c++) begin
      dump_ready = !(c >= 17 && c <= 21);
      @(negedge clk);
      if (c >= 17 && c <= 22) begin
        check("bp_valid", 32'(dump_valid), 32'd1);
        check("bp_idx", 32'(dump_idx), 32'd7);
        check("bp_data", dump_data, 32'd7);
      end
      if (c == 23) check("bp_gap", 32'(dump_valid), 32'd0);
      if (c == 24) begin
        check("bp_next_valid", 32'(dump_valid), 32'd1);
        check("bp_next_idx", 32'(dump_idx), 32'd8);
      end
      if (c == 71) check("bp_done", 32'(done), 32'd1);
      if (c == 72) check("bp_idle", 32'(busy), 32'd0);
      step();
    end
    dump_ready = 1'b1;
    check_queue("bp_q", base, 32, 1'b0);
    check("bp_done_cnt", 32'(done_cnt - dbase), 32'd1);

    // Extra start pulses while busy are ignored.
    base = beats.size(); dbase = done_cnt;
    start = 1'b1;
    step();
    for (int c = 1; c <= 70; c++) begin
      start = (c == 9 || c == 43);
      @(negedge clk);
      if (c == 66) check("sb_done", 32'(done), 32'd1);
      if (c == 67) check("sb_idle", 32'(busy), 32'd0);
      step();
    end
    start = 1'b0;
    check_queue("sb_q", base, 32, 1'b0);
    check("sb_done_cnt", 32'(done_cnt - dbase), 32'd1);

    // Abort in SEND of beat 12 together with a handshake.
    base = beats.size(); dbase = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      abort = (c == 27);
      @(negedge clk);
      if (c == 27) check("ab_beat_idx", 32'(dump_idx), 32'd12);
      if (c == 28) begin
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_stall", 32'(core_stall), 32'd0);
        check("ab_valid", 32'(dump_valid), 32'd0);
      end
      if (c > 27) check("ab_no_done", 32'(done), 32'd0);
      step();
    end
    abort = 1'b0;
    check_queue("ab_q", base, 12, 1'b0);
    check("ab_done_cnt", 32'(done_cnt - dbase), 32'd0);

    // Fresh dump after abort starts again at x0.
    base = beats.size();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("re_valid", 32'(dump_valid), 32'd1);
    check("re_idx", 32'(dump_idx), 32'd0);
    repeat (68) step();
    check_queue("re_q", base, 32, 1'b0);

    // Regfile write in the start cycle is seen by the dump.
    base = beats.size();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; start = 1'b1;
    step();
    we = 1'b0; start = 1'b0;
    repeat (68) step();
    check_queue("wbr_q", base, 32, 1'b1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
